// File: rtl/sram_wr_id.sv
// sram_wr_id: write-side bank/address sequencer for the global buffer.
// Stripes each packet of a valid/ready word stream round-robin across
// SRAM_num banks, emitting registered bank ID, in-bank address, write enable
// and payload; repeats for cyc_num packets and then pulses done.
// Optional feature macro: SRAM_WR_ID_OVF_CHK_EN enables the sticky overflow
// check against SRAM_DEPTH (writes at or beyond the depth are suppressed).
module sram_wr_id #(
    parameter int          DATA_WIDTH   = 64,
    parameter int          ADDR_WIDTH   = 10,
    parameter int unsigned SRAM_DEPTH   = 1024,
    parameter int          CYC_BITWIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [3:0]              SRAM_num,
    input  logic [3:0]              Data_num,
    input  logic [CYC_BITWIDTH-1:0] cyc_num,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    sram_wen,
    output logic [3:0]              Wr_ID,
    output logic [ADDR_WIDTH-1:0]   Wr_Addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    output logic [CYC_BITWIDTH-1:0] Cyc,
    output logic                    done,
    output logic                    ovf
);

`ifdef SRAM_WR_ID_OVF_CHK_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t                  state_r;
    logic [3:0]              sram_num_r;
    logic [3:0]              data_num_r;
    logic [CYC_BITWIDTH-1:0] cyc_num_r;
    logic [3:0]              k_r;        // word index inside the packet
    logic [3:0]              bank_r;     // k mod SRAM_num, kept incrementally
    logic [ADDR_WIDTH-1:0]   row_r;      // k div SRAM_num, kept incrementally
    logic [ADDR_WIDTH-1:0]   base_r;     // first row of the current packet
    logic                    sram_wen_r;
    logic [3:0]              wr_id_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [CYC_BITWIDTH-1:0] cyc_r;
    logic                    done_r;
    logic                    ovf_r;

    logic                    wr_ready_s;
    logic                    beat_s;
    logic [ADDR_WIDTH-1:0]   addr_s;
    logic                    last_word_s;
    logic                    last_bank_s;
    logic                    last_pkt_s;
    logic                    addr_hit_s;

    // Handshake and per-beat address/termination decode.
    always_comb begin
        wr_ready_s  = 1'b0;
        if (state_r == ST_WRITE) begin
            wr_ready_s = ~start & ~abort;
        end else begin
            wr_ready_s = 1'b0;
        end
        beat_s      = wr_valid & wr_ready_s;
        addr_s      = base_r + row_r;
        last_word_s = (k_r == (data_num_r - 4'd1));
        last_bank_s = (bank_r == (sram_num_r - 4'd1));
        last_pkt_s  = (cyc_r == (cyc_num_r - {{(CYC_BITWIDTH-1){1'b0}}, 1'b1}));
        addr_hit_s  = OVF_EN & ({{(32-ADDR_WIDTH){1'b0}}, addr_s} >= SRAM_DEPTH);
    end

    // Job FSM, stripe counters and registered write-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            sram_num_r <= 4'd0;
            data_num_r <= 4'd0;
            cyc_num_r  <= {CYC_BITWIDTH{1'b0}};
            k_r        <= 4'd0;
            bank_r     <= 4'd0;
            row_r      <= {ADDR_WIDTH{1'b0}};
            base_r     <= {ADDR_WIDTH{1'b0}};
            sram_wen_r <= 1'b0;
            wr_id_r    <= 4'd0;
            wr_addr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            cyc_r      <= {CYC_BITWIDTH{1'b0}};
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            sram_wen_r <= 1'b0;
            done_r     <= 1'b0;
            if (start) begin
                // Restart from any state with a freshly latched configuration.
                state_r    <= ST_WRITE;
                sram_num_r <= SRAM_num;
                data_num_r <= Data_num;
                cyc_num_r  <= cyc_num;
                k_r        <= 4'd0;
                bank_r     <= 4'd0;
                row_r      <= {ADDR_WIDTH{1'b0}};
                base_r     <= {ADDR_WIDTH{1'b0}};
                cyc_r      <= {CYC_BITWIDTH{1'b0}};
                ovf_r      <= 1'b0;
            end else if (abort) begin
                state_r <= ST_IDLE;
                k_r     <= 4'd0;
                bank_r  <= 4'd0;
                row_r   <= {ADDR_WIDTH{1'b0}};
                base_r  <= {ADDR_WIDTH{1'b0}};
                cyc_r   <= {CYC_BITWIDTH{1'b0}};
            end else if (beat_s) begin
                if (addr_hit_s) begin
                    // Out-of-range write is dropped; port outputs hold.
                    ovf_r <= 1'b1;
                end else begin
                    sram_wen_r <= 1'b1;
                    wr_id_r    <= bank_r;
                    wr_addr_r  <= addr_s;
                    wdata_r    <= wr_data;
                end
                if (last_word_s) begin
                    // Next packet starts on the row after this packet's last row.
                    k_r    <= 4'd0;
                    bank_r <= 4'd0;
                    row_r  <= {ADDR_WIDTH{1'b0}};
                    base_r <= addr_s + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    cyc_r  <= cyc_r + {{(CYC_BITWIDTH-1){1'b0}}, 1'b1};
                    if (last_pkt_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WRITE;
                    end
                end else begin
                    k_r <= k_r + 4'd1;
                    if (last_bank_s) begin
                        bank_r <= 4'd0;
                        row_r  <= row_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        bank_r <= bank_r + 4'd1;
                    end
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign wr_ready   = wr_ready_s;
    assign sram_wen   = sram_wen_r;
    assign Wr_ID      = wr_id_r;
    assign Wr_Addr    = wr_addr_r;
    assign sram_wdata = wdata_r;
    assign Cyc        = cyc_r;
    assign done       = done_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_sram_wr_id.sv
// Scoreboard bench for sram_wr_id: the driver predicts each write from the
// striping rules with plain arithmetic and queues it; a monitor pops and
// compares whenever the DUT shows sram_wen or done.
module tb_sram_wr_id;

    localparam int DW    = 64;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
`ifdef SRAM_WR_ID_OVF_CHK_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [3:0]    SRAM_num = 4'd1;
    logic [3:0]    Data_num = 4'd1;
    logic [CW-1:0] cyc_num = 8'd1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = 64'd0;
    logic          sram_wen;
    logic [3:0]    Wr_ID;
    logic [AW-1:0] Wr_Addr;
    logic [DW-1:0] sram_wdata;
    logic [CW-1:0] Cyc;
    logic          done;
    logic          ovf;

    sram_wr_id #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRAM_DEPTH(DEPTH), .CYC_BITWIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .SRAM_num(SRAM_num), .Data_num(Data_num), .cyc_num(cyc_num),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .sram_wen(sram_wen), .Wr_ID(Wr_ID), .Wr_Addr(Wr_Addr),
        .sram_wdata(sram_wdata), .Cyc(Cyc), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wen;
        logic [3:0]    id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
        logic [CW-1:0] cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference-model job state
    bit   m_active = 1'b0;
    bit   ovf_exp  = 1'b0;
    int   m_s = 1, m_d = 1, m_c = 1, m_j = 0;
    int   cfg_s = 1, cfg_d = 1, cfg_c = 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus the model's view of what it causes.
    task automatic drive(input bit v, input bit st, input bit ab);
        int p, k, rows, addr;
        bit hit, last;
        exp_t e;
        @(negedge clk);
        chk("ovf", 64'(ovf), 64'(ovf_exp));
        start    = st;
        abort    = ab;
        wr_valid = v;
        wr_data  = {$urandom(), $urandom()};
        SRAM_num = 4'(cfg_s);
        Data_num = 4'(cfg_d);
        cyc_num  = 8'(cfg_c);
        #1;
        chk("wr_ready", 64'(wr_ready), 64'(m_active && !st && !ab));
        if (st) begin
            m_active = 1'b1;
            m_s = cfg_s; m_d = cfg_d; m_c = cfg_c; m_j = 0;
            ovf_exp = 1'b0;
        end else if (ab) begin
            m_active = 1'b0;
        end else if (v && m_active) begin
            p    = m_j / m_d;
            k    = m_j % m_d;
            rows = (m_d + m_s - 1) / m_s;
            addr = (p * rows + k / m_s) % (1 << AW);
            hit  = OVF_ON && (addr >= DEPTH);
            last = (m_j == m_d * m_c - 1);
            if (hit) ovf_exp = 1'b1;
            if (!hit || last) begin
                e.wen  = !hit;
                e.id   = 4'(k % m_s);
                e.addr = AW'(addr);
                e.data = wr_data;
                e.done = last;
                e.cyc  = CW'((k == m_d - 1) ? p + 1 : p);
                q.push_back(e);
            end
            m_j++;
            if (last) m_active = 1'b0;
        end
    endtask

    // mode 0: valid held, 1: valid every other cycle, 2: random valid.
    // cut >= 0 stops after that many beats, leaving the job running.
    task automatic run_job(input int s, input int d, input int c, input int mode, input int cut);
        int budget;
        int it;
        bit v;
        cfg_s = s; cfg_d = d; cfg_c = c;
        drive(1'b0, 1'b1, 1'b0);
        budget = 4000;
        it = 0;
        while (m_active && budget > 0 && (cut < 0 || m_j < cut)) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (it % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            drive(v, 1'b0, 1'b0);
            budget--;
            it++;
        end
        if (budget == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL job_timeout actual=running required=finished");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every DUT write/done event is matched against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && (sram_wen || done)) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_output actual=wen%0b_done%0b id=%0d addr=%0d required=none",
                             sram_wen, done, Wr_ID, Wr_Addr);
                end else begin
                    e = q.pop_front();
                    chk("sram_wen", 64'(sram_wen), 64'(e.wen));
                    chk("done", 64'(done), 64'(e.done));
                    chk("Cyc", 64'(Cyc), 64'(e.cyc));
                    if (e.wen) begin
                        chk("Wr_ID", 64'(Wr_ID), 64'(e.id));
                        chk("Wr_Addr", 64'(Wr_Addr), 64'(e.addr));
                        chk("sram_wdata", sram_wdata, e.data);
                    end
                end
            end
        end
    end

    initial begin
        int s, d, c;
        repeat (3) @(negedge clk);
        chk("rst_sram_wen", 64'(sram_wen), 64'd0);
        chk("rst_Wr_ID", 64'(Wr_ID), 64'd0);
        chk("rst_Wr_Addr", 64'(Wr_Addr), 64'd0);
        chk("rst_sram_wdata", sram_wdata, 64'd0);
        chk("rst_Cyc", 64'(Cyc), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        rst = 1'b0;
        idle(2);

        run_job(4, 10, 1, 0, -1);   // stripe
        idle(2);
        run_job(3, 6, 3, 0, -1);    // multi-packet
        idle(3);
        run_job(2, 4, 2, 1, -1);    // backpressure
        idle(2);
        run_job(4, 10, 1, 0, 5);    // restart at beat 5 ...
        run_job(4, 10, 1, 0, -1);   // ... then a full job from address 0
        idle(2);
        run_job(3, 7, 2, 0, 4);     // abort mid-job
        drive(1'b1, 1'b0, 1'b1);
        idle(3);
        run_job(8, 3, 2, 0, -1);    // more banks than words
        idle(2);
        run_job(1, 6, 1, 0, -1);    // overflow case when the check is enabled
        idle(2);
        run_job(1, 15, 2, 2, -1);   // address wrap
        idle(2);

        for (int n = 0; n < 30; n++) begin
            s = $urandom_range(1, 15);
            d = $urandom_range(1, 15);
            c = $urandom_range(1, 4);
            if ($urandom_range(0, 3) == 0) begin
                run_job(s, d, c, 2, $urandom_range(0, d * c - 1));
                if ($urandom_range(0, 1) == 1) begin
                    drive(1'b1, 1'b0, 1'b1);
                    idle(1);
                end
            end else begin
                run_job(s, d, c, 2, -1);
                idle($urandom_range(0, 2));
            end
        end
        idle(3);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
